// File: rtl/ose_encoder_gen_if.sv
// ============================================================================
// ose_encoder_gen_if : detent step request handshake (valid/ready plus direction)
// Rev 1.0
// ============================================================================
`default_nettype none

interface ose_encoder_gen_if;
  logic step_req;
  logic step_up;
  logic ready;

  modport master (
    output step_req,
    output step_up,
    input  ready
  );

  modport slave (
    input  step_req,
    input  step_up,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/ose_encoder_gen.sv
// ============================================================================
// ose_encoder_gen : quadrature a/b generator, one Gray-coded detent per request
// Rev 1.0
// ============================================================================
`default_nettype none

module ose_encoder_gen #(
  parameter int EDGE_GAP = 5,
  parameter int IDLE_GAP = 10,
  parameter int POS_W    = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  ose_encoder_gen_if.slave      step,
  output logic                  a,
  output logic                  b,
  output logic                  done,
  output logic [POS_W-1:0]      pos
);

  localparam int CNT_W = $clog2(EDGE_GAP + 1);
  localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  localparam logic [CNT_W-1:0] c_ph_last  = CNT_W'(EDGE_GAP - 1);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [GAP_W-1:0] c_gap_one  = GAP_W'(1);
  localparam logic [POS_W-1:0] c_pos_one  = POS_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_PH4  = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt,   w_cnt;
  logic [GAP_W-1:0]   r_gap,   w_gap;
  logic               r_dir,   w_dir;
  logic               r_ready, w_ready;
  logic               r_a,     w_a;
  logic               r_b,     w_b;
  logic               r_done,  w_done;
  logic [POS_W-1:0]   r_pos,   w_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_dir   <= 1'b0;
      r_ready <= 1'b1;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_done  <= 1'b0;
      r_pos   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_gap   <= w_gap;
      r_dir   <= w_dir;
      r_ready <= w_ready;
      r_a     <= w_a;
      r_b     <= w_b;
      r_done  <= w_done;
      r_pos   <= w_pos;
    end
  end

  // Outputs are registered from the next state, so a/b change on the same
  // edge that enters each phase and no input reaches an output combinationally.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_gap   = r_gap;
    w_dir   = r_dir;

    case (r_state)
      ST_IDLE: begin
        if (step.step_req) begin
          w_state = ST_PH1;
          w_cnt   = '0;
          w_dir   = step.step_up;
        end
      end
      ST_PH1, ST_PH2, ST_PH3: begin
        if (r_cnt == c_ph_last) begin
          w_cnt   = '0;
          w_state = (r_state == ST_PH1) ? ST_PH2 :
                    (r_state == ST_PH2) ? ST_PH3 : ST_PH4;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      ST_PH4: begin
        if (r_cnt == c_ph_last) begin
          w_cnt   = '0;
          w_gap   = '0;
          w_state = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      ST_GAP: begin
        if (r_gap == c_gap_last) begin
          w_gap   = '0;
          w_state = ST_IDLE;
        end else begin
          w_gap = r_gap + c_gap_one;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_cnt   = '0;
        w_gap   = '0;
      end
    endcase

    w_ready = (w_state == ST_IDLE);
    w_a     = 1'b0;
    w_b     = 1'b0;
    case (w_state)
      ST_PH1: begin
        w_a = w_dir;
        w_b = ~w_dir;
      end
      ST_PH2: begin
        w_a = 1'b1;
        w_b = 1'b1;
      end
      ST_PH3: begin
        w_a = ~w_dir;
        w_b = w_dir;
      end
      default: begin
        w_a = 1'b0;
        w_b = 1'b0;
      end
    endcase

    w_done = (r_state == ST_PH3) && (w_state == ST_PH4);
    w_pos  = r_pos;
    if (w_done) begin
      w_pos = r_dir ? (r_pos + c_pos_one) : (r_pos - c_pos_one);
    end
  end

  assign step.ready = r_ready;
  assign a          = r_a;
  assign b          = r_b;
  assign done       = r_done;
  assign pos        = r_pos;

endmodule

`default_nettype wire
